// File: rtl/rr_grant_scheduler.sv
// N-way round-robin arbiter with bounded tenure; registered outputs, 1-cycle req-to-gnt latency.
// Owner holds until it drops req or hits MAX_HOLD, then hands over back-to-back or goes idle.
module rr_grant_scheduler #(
   parameter int N        = 4,
   parameter int ID_W     = 2,
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 8
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    gnt,
   output logic [ID_W-1:0] gnt_id,
   output logic            busy,
   output logic            timeout
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t            state, state_n;
   logic [ID_W-1:0]   ptr, ptr_n, gnt_id_n, win;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [N-1:0]      gnt_n, cand, owner_oh;
   logic              busy_n, timeout_n, found, at_limit, rel;
   int                idx, nxt;

   // The current owner is masked out so a releasing owner never wins its own handover.
   always_comb begin
      owner_oh         = '0;
      owner_oh[gnt_id] = 1'b1;
      cand             = (state == GRANT) ? (req & ~owner_oh) : req;
      found            = 1'b0;
      win              = '0;
      idx              = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N) idx = idx - N;
         if (!found && cand[idx[ID_W-1:0]]) begin
            found = 1'b1;
            win   = idx[ID_W-1:0];
         end
      end
      nxt = int'(win) + 1;
      if (nxt == N) nxt = 0;
   end

   assign at_limit = (cnt == CNT_W'(MAX_HOLD - 1));
   assign rel      = !req[gnt_id] || at_limit;

   always_comb begin
      state_n   = state;
      ptr_n     = ptr;
      cnt_n     = cnt;
      gnt_n     = gnt;
      gnt_id_n  = gnt_id;
      busy_n    = busy;
      timeout_n = 1'b0;
      if (state == GRANT && !rel) begin
         cnt_n = cnt + CNT_W'(1);
      end else begin
         if (state == GRANT) timeout_n = req[gnt_id] && at_limit;
         if (found) begin
            gnt_n      = '0;
            gnt_n[win] = 1'b1;
            gnt_id_n   = win;
            busy_n     = 1'b1;
            cnt_n      = '0;
            ptr_n      = nxt[ID_W-1:0];
            state_n    = GRANT;
         end else begin
            gnt_n   = '0;
            busy_n  = 1'b0;
            state_n = IDLE;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         ptr     <= '0;
         cnt     <= '0;
         gnt     <= '0;
         gnt_id  <= '0;
         busy    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state   <= state_n;
         ptr     <= ptr_n;
         cnt     <= cnt_n;
         gnt     <= gnt_n;
         gnt_id  <= gnt_id_n;
         busy    <= busy_n;
         timeout <= timeout_n;
      end
   end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler (N=4, MAX_HOLD=8) with hand-computed grant sequences.
module tb_rr_grant_scheduler;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       busy, timeout;
   int         n_checks = 0;
   int         n_errors = 0;

   rr_grant_scheduler dut (
      .clock   (clock),
      .reset   (reset),
      .req     (req),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .busy    (busy),
      .timeout (timeout)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                             input logic b, input logic t);
      check({tag, ".gnt"}, 32'(gnt), 32'(g));
      check({tag, ".busy"}, 32'(busy), 32'(b));
      check({tag, ".timeout"}, 32'(timeout), 32'(t));
      if (b) check({tag, ".gnt_id"}, 32'(gnt_id), 32'(id));
   endtask

   // Advance one rising edge and settle on the following falling edge.
   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      req   = 4'b0000;
      tick();
      tick();
      expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      check("reset.gnt_id", 32'(gnt_id), 32'd0);
      reset = 1'b0;

      // No requests: stays idle.
      for (int c = 0; c < 5; c++) begin
         tick();
         expect_out("idle", 4'b0000, 2'd0, 1'b0, 1'b0);
         check("idle.gnt_id", 32'(gnt_id), 32'd0);
      end

      // Two contenders with tenure limit: 0 for 8, 2 for 8, back to 0.
      req = 4'b0101;
      for (int c = 0; c < 8; c++) begin
         tick();
         expect_out("pair.r0", 4'b0001, 2'd0, 1'b1, 1'b0);
      end
      tick();
      expect_out("pair.to2", 4'b0100, 2'd2, 1'b1, 1'b1);
      for (int c = 0; c < 7; c++) begin
         tick();
         expect_out("pair.r2", 4'b0100, 2'd2, 1'b1, 1'b0);
      end
      tick();
      expect_out("pair.to0", 4'b0001, 2'd0, 1'b1, 1'b1);
      req = 4'b0000;
      tick();
      expect_out("pair.drop", 4'b0000, 2'd0, 1'b0, 1'b0);

      // Lone requester: 8 cycles, one idle cycle with timeout, then re-granted.
      req = 4'b1000;
      for (int c = 0; c < 8; c++) begin
         tick();
         expect_out("lone.hold", 4'b1000, 2'd3, 1'b1, 1'b0);
      end
      tick();
      expect_out("lone.gap", 4'b0000, 2'd0, 1'b0, 1'b1);
      tick();
      expect_out("lone.regrant", 4'b1000, 2'd3, 1'b1, 1'b0);
      req = 4'b0000;
      tick();
      expect_out("lone.drop", 4'b0000, 2'd0, 1'b0, 1'b0);

      // All requesting, each owner drops one cycle after its grant: order 0,1,2,3,0.
      req = 4'b1111;
      tick();
      expect_out("all.first", 4'b0001, 2'd0, 1'b1, 1'b0);
      for (int o = 0; o < 4; o++) begin
         tick();
         expect_out("all.hold", 4'(1 << o), 2'(o), 1'b1, 1'b0);
         req = 4'b1111 & ~4'(1 << o);
         tick();
         expect_out("all.hand", 4'(1 << ((o + 1) % 4)), 2'((o + 1) % 4), 1'b1, 1'b0);
         req = 4'b1111;
      end

      // Owner 0 (ptr=1) drops, 2 takes over (ptr=3); 2 drops as 1 rises -> 1.
      req = 4'b0100;
      tick();
      expect_out("rise.own2", 4'b0100, 2'd2, 1'b1, 1'b0);
      tick();
      expect_out("rise.hold2", 4'b0100, 2'd2, 1'b1, 1'b0);
      req = 4'b0010;
      tick();
      expect_out("rise.own1", 4'b0010, 2'd1, 1'b1, 1'b0);
      req = 4'b0001;
      tick();
      expect_out("rise.own0", 4'b0001, 2'd0, 1'b1, 1'b0);
      req = 4'b0000;
      tick();
      expect_out("rise.idle", 4'b0000, 2'd0, 1'b0, 1'b0);
      // ptr=1 now, so requester 1 beats lower-index 0.
      req = 4'b0011;
      tick();
      expect_out("ptr.pick", 4'b0010, 2'd1, 1'b1, 1'b0);
      req = 4'b0000;
      tick();
      expect_out("ptr.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

      // Reset mid-tenure (owner 2, cnt=5) drops grant and clears ptr.
      req = 4'b0100;
      tick();
      expect_out("mid.grant", 4'b0100, 2'd2, 1'b1, 1'b0);
      for (int c = 0; c < 5; c++) begin
         tick();
         expect_out("mid.hold", 4'b0100, 2'd2, 1'b1, 1'b0);
      end
      reset = 1'b1;
      tick();
      expect_out("mid.reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      check("mid.reset.gnt_id", 32'(gnt_id), 32'd0);
      reset = 1'b0;
      req   = 4'b0110;
      tick();
      expect_out("mid.after", 4'b0010, 2'd1, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
